// File: rtl/sprite_rom_square.sv
// 2x2 sprite renderer: a fixed reference marker plus an offset-shifted copy,
// both looked up in a 4-entry colour ROM and registered to q with pixel_pos.
module sprite_rom_square #(
    parameter logic [10:0] BASE_ROW = 11'd100,
    parameter logic [10:0] BASE_COL = 11'd100,
    parameter logic [11:0] COLOR_A  = 12'hF00,
    parameter logic [11:0] COLOR_B  = 12'h0F0,
    parameter logic [11:0] COLOR_BG = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] row,
    input  logic [10:0] column,
    input  logic [10:0] row_offset,
    input  logic [10:0] column_offset,
    output logic [43:0] pixel_pos,
    output logic [11:0] q
);

    localparam logic [10:0] BASE_ROW_1 = BASE_ROW + 11'd1;
    localparam logic [10:0] BASE_COL_1 = BASE_COL + 11'd1;

    logic [10:0] top;
    logic [10:0] bottom;
    logic [10:0] left;
    logic [10:0] right;

    logic        shift_row_hit;
    logic        shift_col_hit;
    logic        base_row_hit;
    logic        base_col_hit;
    logic [1:0]  shift_idx;
    logic [1:0]  base_idx;
    logic [11:0] q_next;

    function automatic logic [11:0] rom_lookup(input logic [1:0] idx);
        logic [11:0] color;
        case (idx)
            2'b00:   color = COLOR_A;
            2'b01:   color = COLOR_B;
            2'b10:   color = COLOR_B;
            default: color = COLOR_A;
        endcase
        return color;
    endfunction

    // Offsets are two's complement, so plain 11-bit addition wraps correctly
    // and a footprint straddling 2047->0 still matches by equality.
    always_comb begin
        top    = BASE_ROW + row_offset;
        bottom = BASE_ROW_1 + row_offset;
        left   = BASE_COL + column_offset;
        right  = BASE_COL_1 + column_offset;
    end

    always_comb begin
        shift_row_hit = (row == top) || (row == bottom);
        shift_col_hit = (column == left) || (column == right);
        shift_idx     = {row == bottom, column == right};

        base_row_hit  = (row == BASE_ROW) || (row == BASE_ROW_1);
        base_col_hit  = (column == BASE_COL) || (column == BASE_COL_1);
        base_idx      = {row == BASE_ROW_1, column == BASE_COL_1};

        q_next = COLOR_BG;
        if (shift_row_hit && shift_col_hit) begin
            q_next = rom_lookup(shift_idx);
        end else if (base_row_hit && base_col_hit) begin
            q_next = rom_lookup(base_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= 12'h000;
            pixel_pos <= 44'h0;
        end else begin
            q         <= q_next;
            pixel_pos <= {right, left, bottom, top};
        end
    end

endmodule

// File: tb/tb_sprite_rom_square.sv
// Directed bench for sprite_rom_square: hand-computed colours and corners,
// including wrap-around, shifted-over-base priority and async reset.
module tb_sprite_rom_square;

    logic        clk;
    logic        rst_n;
    logic [10:0] row;
    logic [10:0] column;
    logic [10:0] row_offset;
    logic [10:0] column_offset;
    logic [43:0] pixel_pos;
    logic [11:0] q;

    int checks = 0;
    int errors = 0;

    sprite_rom_square dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .row           (row),
        .column        (column),
        .row_offset    (row_offset),
        .column_offset (column_offset),
        .pixel_pos     (pixel_pos),
        .q             (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] corners(input int t, input int b, input int l, input int r);
        logic [10:0] t11, b11, l11, r11;
        t11 = 11'(t);
        b11 = 11'(b);
        l11 = 11'(l);
        r11 = 11'(r);
        return {r11, l11, b11, t11};
    endfunction

    // Drive inputs just after an edge, let the next edge register them, sample 1ns later.
    task automatic apply(input int r, input int c, input int roff, input int coff);
        row           = 11'(r);
        column        = 11'(c);
        row_offset    = 11'(roff);
        column_offset = 11'(coff);
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int r, input int c, input int roff,
                       input int coff, input logic [11:0] exp_q);
        apply(r, c, roff, coff);
        check(tag, {32'h0, q}, {32'h0, exp_q});
    endtask

    initial begin
        rst_n         = 1'b0;
        row           = 11'd100;
        column        = 11'd100;
        row_offset    = 11'd0;
        column_offset = 11'd0;
        #2;
        check("rst_q", {32'h0, q}, 44'h0);
        check("rst_pos", pixel_pos, 44'h0);
        @(posedge clk);
        #1;
        check("rst_hold_q", {32'h0, q}, 44'h0);
        #3 rst_n = 1'b1;

        // first edge after release loads from live inputs (base hit, offset zero)
        @(posedge clk);
        #1;
        check("first_q", {32'h0, q}, {32'h0, 12'hF00});
        check("first_pos", pixel_pos, corners(100, 101, 100, 101));

        apply(0, 0, -50, 50);
        check("r028_q", {32'h0, q}, 44'h0);
        check("r028_pos", pixel_pos, corners(50, 51, 150, 151));

        pix("bg_700_500", 700, 500, -50, 50, 12'h000);
        pix("base_00", 100, 100, -50, 50, 12'hF00);
        pix("base_01", 100, 101, -50, 50, 12'h0F0);
        pix("base_10", 101, 100, -50, 50, 12'h0F0);
        pix("base_11", 101, 101, -50, 50, 12'hF00);
        pix("shift_00", 50, 150, -50, 50, 12'hF00);
        pix("shift_01", 50, 151, -50, 50, 12'h0F0);
        pix("shift_10", 51, 150, -50, 50, 12'h0F0);
        pix("shift_11", 51, 151, -50, 50, 12'hF00);
        pix("edge_miss", 52, 151, -50, 50, 12'h000);

        apply(0, 0, -75, 75);
        check("r031_pos", pixel_pos, corners(25, 26, 175, 176));

        // shifted footprint overlaps base: shifted ROM index wins
        pix("prio_101_100", 101, 100, 1, 0, 12'hF00);
        pix("prio_102_101", 102, 101, 1, 0, 12'hF00);
        pix("prio_base_100_101", 100, 101, 1, 0, 12'h0F0);
        pix("prio_base_100_100", 100, 100, 1, 0, 12'hF00);

        pix("zero_off_01", 100, 101, 0, 0, 12'h0F0);
        pix("zero_off_10", 101, 100, 0, 0, 12'h0F0);

        pix("wrap_row_top", 2047, 100, -101, 0, 12'hF00);
        check("wrap_row_pos", pixel_pos, corners(2047, 0, 100, 101));
        pix("wrap_row_bot", 0, 101, -101, 0, 12'hF00);
        pix("wrap_row_mix", 0, 100, -101, 0, 12'h0F0);
        pix("wrap_col", 100, 0, 0, -101, 12'h0F0);

        // asynchronous reset between edges
        apply(100, 100, 0, 0);
        check("pre_rst_q", {32'h0, q}, {32'h0, 12'hF00});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", {32'h0, q}, 44'h0);
        check("async_rst_pos", pixel_pos, 44'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_q", {32'h0, q}, {32'h0, 12'hF00});
        check("post_rst_pos", pixel_pos, corners(100, 101, 100, 101));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sprite_rom_square.md
SPRITE_ROM_SQUARE -- requirements
Module: sprite_ROM_square

Interface
REQ-001 Parameter BASE_ROW, default 11'd100: unshifted sprite top row.
REQ-002 Parameter BASE_COL, default 11'd100: unshifted sprite left column.
REQ-003 Parameter COLOR_A, default 12'hF00: colour of ROM entries 0 and 3 (red).
REQ-004 Parameter COLOR_B, default 12'h0F0: colour of ROM entries 1 and 2 (green).
REQ-005 Parameter COLOR_BG, default 12'h000: output colour when no sprite is hit.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  input  1  rising-edge clock for all registers.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 row  input  11  current scan row, unsigned.
REQ-010 column  input  11  current scan column, unsigned.
REQ-011 row_offset  input  11  signed two's-complement vertical displacement of the sprite.
REQ-012 column_offset  input  11  signed two's-complement horizontal displacement of the sprite.
REQ-013 pixel_pos  output  44  registered sprite corners: [10:0] top row, [21:11] bottom row, [32:22] left column, [43:33] right column.
REQ-014 q  output  12  registered 4-4-4 RGB pixel colour.

Function
REQ-015 Sprite SHALL be a 2x2 ROM of 12-bit colours, index {dr,dc}: 00=COLOR_A, 01=COLOR_B, 10=COLOR_B, 11=COLOR_A.
REQ-016 Shifted footprint: top=BASE_ROW+row_offset, bottom=BASE_ROW+1+row_offset, left=BASE_COL+column_offset, right=BASE_COL+1+column_offset; all sums 11-bit, modulo 2^11 (wrap, no saturation).
REQ-017 pixel_pos SHALL register {right,left,bottom,top} every clock, 1-cycle latency from any offset change.
REQ-018 Shifted hit: row equals top or bottom AND column equals left or right (11-bit equality); dr=(row==bottom), dc=(column==right).
REQ-019 Base hit: row in {BASE_ROW, BASE_ROW+1} AND column in {BASE_COL, BASE_COL+1}; dr=row-BASE_ROW, dc=column-BASE_COL; the base footprint is a fixed reference marker always drawn.
REQ-020 Priority: shifted hit selects ROM[{dr,dc}] of the shifted footprint; else base hit selects ROM of base footprint; else COLOR_BG.
REQ-021 q SHALL be registered with exactly 1-cycle latency from row/column/offset inputs.
REQ-022 Offset zero: both footprints coincide; result identical to either.
REQ-023 Wrap case: a footprint straddling 2047->0 SHALL still match by modular equality (e.g. top=2047, bottom=0).
REQ-024 No handshake; inputs are sampled every rising clk edge.

Reset
REQ-025 While rst_n=0, q SHALL be 12'h000 and pixel_pos SHALL be 44'h0, asynchronously.
REQ-026 First rising edge after rst_n deasserts SHALL load values computed from current inputs.
REQ-027 Reset asserted mid-operation SHALL clear outputs immediately, regardless of clk.

Verification
REQ-028 offsets -50/+50, row=0,col=0 -> next cycle q=12'h000, pixel_pos fields top=50, bottom=51, left=150, right=151.
REQ-029 offsets -50/+50, (row,col)=(700,500) -> q=12'h000; (100,100)->F00, (100,101)->0F0, (101,100)->0F0, (101,101)->F00.
REQ-030 offsets -50/+50, (50,150)->F00, (50,151)->0F0, (51,150)->0F0, (51,151)->F00.
REQ-031 offsets changed to -75/+75 -> after one clock top=25, bottom=26, left=175, right=176.
REQ-032 row_offset=-101 (11'h79B), column_offset=0, (row,col)=(2047,100) -> q=F00; (0,101) -> F00.
REQ-033 Assert rst_n=0 between clock edges with q=F00 -> q=000 and pixel_pos=0 immediately; release -> valid values after next edge.
